// File: rtl/unstripe_sched.sv
// unstripe_sched: merges two striped lanes into one stream by strict 0/1 alternation.
// Lane skew checking is compiled in only when UNSTRIPE_SKEW_CHECK_EN is defined.
module unstripe_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int SKEW_LIMIT = 8
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic        valid_0,
  input  logic [31:0] lane_0,
  input  logic        valid_1,
  input  logic [31:0] lane_1,
  input  logic        ready_out,
  output logic        full_0,
  output logic        full_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic [15:0] word_cnt,
  output logic        skew_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {EXP0, EXP1} state_t;
  state_t state;
  logic [1:0] valid_in, full, nonempty, push, pop;
  logic [1:0][31:0] lane, head;
  logic slot;
  if (FIFO_DEPTH < 2 || SKEW_LIMIT < 1) begin : g_bad_param
    $error("unstripe_sched: FIFO_DEPTH must be >= 2 and SKEW_LIMIT >= 1");
  end
  assign valid_in = {valid_1, valid_0};
  assign lane = {lane_1, lane_0};
  assign full_0 = full[0];
  assign full_1 = full[1];
  // full comes from the registered count, so a same-edge pop never frees a slot for a push
  assign push = valid_in & ~full;
  assign slot = !valid_out || ready_out;
  assign pop = {state == EXP1, state == EXP0} & nonempty & {2{slot}};
  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign full[i] = cnt == (AW+1)'(FIFO_DEPTH);
    assign nonempty[i] = cnt != '0;
    assign head[i] = mem[rp];
    always_ff @(posedge clk_2f)
      if (push[i]) mem[wp] <= lane[i];
    always_ff @(posedge clk_2f or negedge reset)
      if (!reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push[i]) wp <= wp + 1'b1;
        if (pop[i]) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
  end
  always_ff @(posedge clk_2f or negedge reset)
    if (!reset) begin
      state <= EXP0;
      data_out <= '0;
      valid_out <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (|pop) begin
        data_out <= head[state == EXP1];
        valid_out <= 1'b1;
        state <= state == EXP0 ? EXP1 : EXP0;
      end else if (ready_out) valid_out <= 1'b0;
      if (valid_out && ready_out) word_cnt <= word_cnt + 16'd1;
    end
`ifdef UNSTRIPE_SKEW_CHECK_EN
  localparam int SW = $clog2(SKEW_LIMIT + 1);
  logic [SW-1:0] skew_cnt;
  logic starve;
  // expected lane dry while the other lane has backed up completely
  assign starve = state == EXP0 ? !nonempty[0] && full[1] : !nonempty[1] && full[0];
  always_ff @(posedge clk_2f or negedge reset)
    if (!reset) begin
      skew_cnt <= '0;
      skew_err <= 1'b0;
    end else begin
      if (|pop) skew_cnt <= '0;
      else if (starve && skew_cnt != SW'(SKEW_LIMIT)) skew_cnt <= skew_cnt + 1'b1;
      if (starve && skew_cnt >= SW'(SKEW_LIMIT - 1)) skew_err <= 1'b1;
    end
`else
  assign skew_err = 1'b0;
`endif
endmodule

// File: tb/tb_unstripe_sched.sv
// tb_unstripe_sched: scoreboard bench for unstripe_sched; lane queues model the alternating merge.
module tb_unstripe_sched;
  logic clk_2f, reset, valid_0, valid_1, ready_out;
  logic [31:0] lane_0, lane_1, data_out;
  logic full_0, full_1, valid_out, skew_err;
  logic [15:0] word_cnt;
  int vecs = 0, errs = 0, n_hs = 0;
  logic exp_lane = 1'b0;
  logic [31:0] q0[$], q1[$], outs[$];
`ifdef UNSTRIPE_SKEW_CHECK_EN
  localparam logic SKEW_EXP = 1'b1;
`else
  localparam logic SKEW_EXP = 1'b0;
`endif

  unstripe_sched dut (
    .clk_2f(clk_2f), .reset(reset), .valid_0(valid_0), .lane_0(lane_0),
    .valid_1(valid_1), .lane_1(lane_1), .ready_out(ready_out),
    .full_0(full_0), .full_1(full_1), .data_out(data_out), .valid_out(valid_out),
    .word_cnt(word_cnt), .skew_err(skew_err)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_2f) if (reset) begin
    if (valid_out && ready_out) begin
      outs.push_back(data_out);
      n_hs++;
      if (exp_lane ? q1.size() == 0 : q0.size() == 0) check("underflow", 32'd1, 32'd0);
      else check("data", data_out, exp_lane ? q1.pop_front() : q0.pop_front());
      exp_lane = ~exp_lane;
    end
    if (valid_0 && !full_0) q0.push_back(lane_0);
    if (valid_1 && !full_1) q1.push_back(lane_1);
  end

  task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    @(posedge clk_2f);
    #1;
    valid_0 = v0;
    lane_0 = d0;
    valid_1 = v1;
    lane_1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    outs.delete();
    exp_lane = 1'b0;
    n_hs = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
    model_clear();
    @(posedge clk_2f);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk_2f);
    while ((q0.size() != 0 || q1.size() != 0 || valid_out) && n < 200) begin
      @(negedge clk_2f);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    lane_0 = '0;
    lane_1 = '0;
    ready_out = 1'b1;
    #2;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_full", {30'd0, full_1, full_0}, 32'd0);
    check("rst_skew", 32'(skew_err), 32'd0);
    @(posedge clk_2f);
    #1;
    reset = 1'b1;

    // alternation
    drive(1'b1, 32'hFFFFFFFF, 1'b1, 32'hEEEEEEEE);
    drive(1'b1, 32'hDDDDDDDD, 1'b1, 32'hCCCCCCCC);
    idle();
    drain();
    check("alt_n", outs.size(), 32'd4);
    if (outs.size() == 4) begin
      check("alt_0", outs[0], 32'hFFFFFFFF);
      check("alt_1", outs[1], 32'hEEEEEEEE);
      check("alt_2", outs[2], 32'hDDDDDDDD);
      check("alt_3", outs[3], 32'hCCCCCCCC);
    end
    check("alt_cnt", 32'(word_cnt), 32'd4);

    // skewed lanes: lane 1 early by 3 cycles
    pulse_reset();
    drive(1'b0, 32'd0, 1'b1, 32'd4);
    drive(1'b0, 32'd0, 1'b1, 32'd6);
    idle();
    drive(1'b1, 32'd3, 1'b0, 32'd0);
    drive(1'b1, 32'd5, 1'b0, 32'd0);
    idle();
    drain();
    check("skw_n", outs.size(), 32'd4);
    for (int k = 0; k < 4 && k < outs.size(); k++) check("skw_ord", outs[k], 32'(k + 3));

    // backpressure
    pulse_reset();
    ready_out = 1'b0;
    for (int k = 0; k < 10; k++) drive(1'b1, 32'h100 + k, 1'b1, 32'h200 + k);
    idle();
    @(negedge clk_2f);
    check("bp_full0", 32'(full_0), 32'd1);
    check("bp_full1", 32'(full_1), 32'd1);
    check("bp_valid", 32'(valid_out), 32'd1);
    check("bp_held", data_out, 32'h100);
    check("bp_cnt0", 32'(word_cnt), 32'd0);
    ready_out = 1'b1;
    drain();
    check("bp_words", n_hs, 32'd9);
    check("bp_cnt", 32'(word_cnt), 32'd9);

    // reset mid-stream with three words in flight
    ready_out = 1'b0;
    drive(1'b1, 32'hA0, 1'b1, 32'hB0);
    drive(1'b1, 32'hA1, 1'b0, 32'd0);
    idle();
    @(posedge clk_2f);
    #3;
    reset = 1'b0;
    #1;
    check("mr_valid", 32'(valid_out), 32'd0);
    check("mr_cnt", 32'(word_cnt), 32'd0);
    check("mr_full", {30'd0, full_1, full_0}, 32'd0);
    model_clear();
    @(posedge clk_2f);
    #1;
    reset = 1'b1;
    ready_out = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 32'hB9);
    drive(1'b1, 32'hA9, 1'b0, 32'd0);
    idle();
    drain();
    check("mr_n", outs.size(), 32'd2);
    if (outs.size() == 2) begin
      check("mr_first", outs[0], 32'hA9);
      check("mr_second", outs[1], 32'hB9);
    end

    // skew: lane 1 fills, lane 0 idle
    pulse_reset();
    for (int k = 0; k < 4; k++) drive(1'b0, 32'd0, 1'b1, 32'h300 + k);
    idle();
    repeat (12) @(posedge clk_2f);
    @(negedge clk_2f);
    check("sk_err", 32'(skew_err), 32'(SKEW_EXP));
    check("sk_nopop", 32'(valid_out), 32'd0);
    check("sk_full1", 32'(full_1), 32'd1);
    for (int k = 0; k < 4; k++) drive(1'b1, 32'h400 + k, 1'b0, 32'd0);
    idle();
    drain();
    check("sk_sticky", 32'(skew_err), 32'(SKEW_EXP));
    check("sk_n", n_hs, 32'd8);

    // word counter wrap
    pulse_reset();
    for (int i = 0; i < 65535; i++) drive(i[0] == 1'b0, 32'(i), i[0] == 1'b1, 32'(i));
    idle();
    drain();
    check("wrap_max", 32'(word_cnt), 32'h0000FFFF);
    drive(1'b0, 32'd0, 1'b1, 32'h12345678);
    idle();
    drain();
    check("wrap_zero", 32'(word_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
